// File: rtl/mem_responder_if.sv
// Core-to-memory request bus: level request, registered ready/read data.
// Master drives the request side, slave answers it.
interface mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: RAM with wait states, one I/O-mapped address
// and a side preload port.
module mem_responder #(
    parameter int              ADDR_W      = 8,
    parameter int              DATA_W      = 8,
    parameter int              WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR   = ADDR_W'(8'hFF)
) (
    input  logic              clk,
    input  logic              rst,
    mem_responder_if.slave    bus,
    output logic              busy,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out,
    output logic              io_strobe,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [DATA_W-1:0] ram [2**ADDR_W];

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] a_addr;
    logic              a_we;
    logic [DATA_W-1:0] a_wdata;

    logic commit;
    logic a_io;
    logic core_wr_ram;
    logic load_ok;

    assign commit      = (state == S_WAIT) && (cnt == 4'd0) && !rst;
    assign a_io        = (a_addr == IO_ADDR);
    assign core_wr_ram = commit && a_we && !a_io;
    assign load_ok     = load_we && (load_addr != IO_ADDR);
    assign busy        = (state != S_IDLE);

    // RAM writes: the core write is issued last so it wins a same-address load.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            ram[load_addr] <= load_data;
        end
        if (core_wr_ram) begin
            ram[a_addr] <= a_wdata;
        end
    end

    // Request FSM: accept, count wait states, commit, then hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= 4'd0;
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
            io_out        <= '0;
            io_strobe     <= 1'b0;
        end else begin
            io_strobe <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.mem_req) begin
                        a_addr  <= bus.mem_addr;
                        a_we    <= bus.mem_we;
                        a_wdata <= bus.mem_wdata;
                        cnt     <= WAIT_INIT;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (a_we) begin
                            if (a_io) begin
                                io_out    <= a_wdata;
                                io_strobe <= 1'b1;
                            end
                        end else if (bus.mem_req) begin
                            bus.mem_rdata <= a_io ? io_in : ram[a_addr];
                        end
                        if (bus.mem_req) begin
                            bus.mem_ready <= 1'b1;
                            state         <= S_RESP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_RESP: begin
                    if (!bus.mem_req) begin
                        bus.mem_ready <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance 0 uses two wait states, instance 1 none.
// A transaction-level model per instance is compared after every clock edge.
module tb_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req    [2];
    logic [7:0] addr   [2];
    logic       we     [2];
    logic [7:0] wdata  [2];
    logic [7:0] io_in  [2];
    logic       ldwe   [2];
    logic [7:0] ldaddr [2];
    logic [7:0] lddata [2];
    logic [7:0] rdata_o  [2];
    logic [7:0] io_out_o [2];
    logic       ready_o  [2];
    logic       busy_o   [2];
    logic       strobe_o [2];

    int errors = 0;
    int checks = 0;
    int nstb [2];
    bit live = 1'b0;

    for (genvar g = 0; g < 2; g++) begin : gm
        localparam int W = (g == 0) ? 2 : 0;

        mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus ();

        assign bus.mem_req   = req[g];
        assign bus.mem_addr  = addr[g];
        assign bus.mem_we    = we[g];
        assign bus.mem_wdata = wdata[g];
        assign rdata_o[g]    = bus.mem_rdata;
        assign ready_o[g]    = bus.mem_ready;

        mem_responder #(
            .ADDR_W(8), .DATA_W(8),
            .WAIT_CYCLES(W), .IO_ADDR(8'hFF)
        ) dut (
            .clk(clk), .rst(rst), .bus(bus.slave),
            .busy(busy_o[g]), .io_in(io_in[g]),
            .io_out(io_out_o[g]), .io_strobe(strobe_o[g]),
            .load_we(ldwe[g]), .load_addr(ldaddr[g]),
            .load_data(lddata[g])
        );

        // Model: a request accepted on edge e commits on edge e+1+W.
        logic [7:0] ram [256];
        int         e    = 0;
        int         cat  = 0;
        bit         pend = 1'b0;
        bit         resp = 1'b0;
        logic [7:0] la, lwd;
        logic       lw;
        logic [7:0] x_rdata, x_io;
        logic       x_ready, x_stb;

        always @(posedge clk) begin
            e     <= e + 1;
            x_stb <= 1'b0;
            if (ldwe[g] && ldaddr[g] != 8'hFF) ram[ldaddr[g]] <= lddata[g];
            if (rst) begin
                pend    <= 1'b0;
                resp    <= 1'b0;
                x_ready <= 1'b0;
                x_rdata <= 8'h00;
                x_io    <= 8'h00;
            end else if (resp) begin
                if (!req[g]) begin
                    resp    <= 1'b0;
                    x_ready <= 1'b0;
                end
            end else if (pend) begin
                if (e == cat) begin
                    pend <= 1'b0;
                    if (lw) begin
                        if (la == 8'hFF) begin
                            x_io  <= lwd;
                            x_stb <= 1'b1;
                        end else begin
                            ram[la] <= lwd;
                        end
                    end else if (req[g]) begin
                        x_rdata <= (la == 8'hFF) ? io_in[g] : ram[la];
                    end
                    if (req[g]) begin
                        resp    <= 1'b1;
                        x_ready <= 1'b1;
                    end
                end
            end else if (req[g]) begin
                pend <= 1'b1;
                la   <= addr[g];
                lw   <= we[g];
                lwd  <= wdata[g];
                cat  <= e + 1 + W;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_one(input int i, input logic [7:0] xr,
                           input logic [7:0] xio, input logic xrdy,
                           input logic xb, input logic xs);
        chk($sformatf("m%0d_ready", i), int'(ready_o[i]), int'(xrdy));
        chk($sformatf("m%0d_rdata", i), int'(rdata_o[i]), int'(xr));
        chk($sformatf("m%0d_busy", i), int'(busy_o[i]), int'(xb));
        chk($sformatf("m%0d_io_out", i), int'(io_out_o[i]), int'(xio));
        chk($sformatf("m%0d_strobe", i), int'(strobe_o[i]), int'(xs));
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        if (strobe_o[0]) nstb[0]++;
        if (strobe_o[1]) nstb[1]++;
        if (live) begin
            cmp_one(0, gm[0].x_rdata, gm[0].x_io, gm[0].x_ready,
                    gm[0].pend | gm[0].resp, gm[0].x_stb);
            cmp_one(1, gm[1].x_rdata, gm[1].x_io, gm[1].x_ready,
                    gm[1].pend | gm[1].resp, gm[1].x_stb);
        end
    endtask

    function automatic int wc(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic load(input int i, input logic [7:0] a, input logic [7:0] d);
        ldwe[i]   = 1'b1;
        ldaddr[i] = a;
        lddata[i] = d;
        step();
        ldwe[i] = 1'b0;
    endtask

    // Full handshake; an optional load is presented on the commit edge.
    task automatic access(input int i, input logic w, input logic [7:0] a,
                          input logic [7:0] d, input bit ld,
                          input logic [7:0] la, input logic [7:0] ldd,
                          output logic [7:0] rd);
        req[i]   = 1'b1;
        we[i]    = w;
        addr[i]  = a;
        wdata[i] = d;
        repeat (wc(i) + 1) step();
        chk("ready_early", int'(ready_o[i]), 0);
        if (ld) begin
            ldwe[i]   = 1'b1;
            ldaddr[i] = la;
            lddata[i] = ldd;
        end
        addr[i]  = 8'h00;
        wdata[i] = 8'h00;
        step();
        ldwe[i] = 1'b0;
        chk("ready_latency", int'(ready_o[i]), 1);
        rd = rdata_o[i];
        step();
        chk("ready_hold", int'(ready_o[i]), 1);
        chk("rdata_hold", int'(rdata_o[i]), int'(rd));
        req[i] = 1'b0;
        step();
        chk("ready_drop", int'(ready_o[i]), 0);
    endtask

    logic [7:0] rd;
    int         s0;
    bit         seen;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            nstb[i] = 0;  req[i] = 1'b0;  addr[i] = 8'h00;
            we[i] = 1'b0; wdata[i] = 8'h00; io_in[i] = 8'h00;
            ldwe[i] = 1'b0; ldaddr[i] = 8'h00; lddata[i] = 8'h00;
        end
        step();
        step();
        rst  = 1'b0;
        live = 1'b1;
        step();
        chk("rst_ready", int'(ready_o[0]), 0);
        chk("rst_busy", int'(busy_o[0]), 0);
        chk("rst_rdata", int'(rdata_o[0]), 0);
        chk("rst_io_out", int'(io_out_o[0]), 0);

        load(0, 8'h10, 8'h5A);
        access(0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 8'h00, rd);
        chk("read_10", int'(rd), 'h5A);

        access(0, 1'b1, 8'h20, 8'h33, 1'b0, 8'h00, 8'h00, rd);
        access(0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 8'h00, rd);
        chk("read_20", int'(rd), 'h33);

        s0 = nstb[0];
        access(0, 1'b1, 8'hFF, 8'h77, 1'b0, 8'h00, 8'h00, rd);
        chk("io_out_77", int'(io_out_o[0]), 'h77);
        chk("io_strobe_cnt", nstb[0] - s0, 1);
        io_in[0] = 8'h00;
        access(0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, rd);
        chk("read_io_00", int'(rd), 'h00);
        io_in[0] = 8'h3C;
        access(0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, rd);
        chk("read_io_3c", int'(rd), 'h3C);

        access(0, 1'b1, 8'h40, 8'h11, 1'b1, 8'h40, 8'h22, rd);
        access(0, 1'b0, 8'h40, 8'h00, 1'b0, 8'h00, 8'h00, rd);
        chk("wr_beats_load", int'(rd), 'h11);
        load(0, 8'h41, 8'h12);
        access(0, 1'b0, 8'h41, 8'h00, 1'b1, 8'h41, 8'h99, rd);
        chk("rd_pre_load", int'(rd), 'h12);
        access(0, 1'b0, 8'h41, 8'h00, 1'b0, 8'h00, 8'h00, rd);
        chk("rd_post_load", int'(rd), 'h99);

        load(0, 8'h05, 8'h00);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h05; wdata[0] = 8'hAB;
        step();
        step();
        req[0] = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            step();
            if (ready_o[0]) seen = 1'b1;
        end
        chk("abort_no_ready", int'(seen), 0);
        chk("abort_idle", int'(busy_o[0]), 0);
        access(0, 1'b0, 8'h05, 8'h00, 1'b0, 8'h00, 8'h00, rd);
        chk("abort_wr_kept", int'(rd), 'hAB);

        load(0, 8'h06, 8'h44);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h06; wdata[0] = 8'hCD;
        step();
        step();
        rst    = 1'b1;
        req[0] = 1'b0;
        step();
        chk("rst_mid_ready", int'(ready_o[0]), 0);
        chk("rst_mid_busy", int'(busy_o[0]), 0);
        rst = 1'b0;
        step();
        access(0, 1'b0, 8'h06, 8'h00, 1'b0, 8'h00, 8'h00, rd);
        chk("rst_wr_dropped", int'(rd), 'h44);

        for (int k = 0; k < 4; k++) load(1, 8'(k), 8'(8'hA0 + k));
        for (int k = 0; k < 4; k++) begin
            access(1, 1'b0, 8'(k), 8'h00, 1'b0, 8'h00, 8'h00, rd);
            chk($sformatf("w0_read_%0d", k), int'(rd), 'hA0 + k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the 8-bit core's request bus (mem_req / mem_ready four-phase handshake).
- Holds a 2^ADDR_W x DATA_W RAM, inserts a configurable number of wait states, and maps one address to an I/O port.
- Has a side load port so the bench or boot logic can preload program memory.
- Sits at top level between the core's addr/data_out/we/mem_req outputs and its data_in/mem_ready inputs.

Parameters:
ADDR_W, 8, address width; RAM depth is 2^ADDR_W.
DATA_W, 8, data width.
WAIT_CYCLES, 2, wait states between request acceptance and access commit (0 allowed, max 15).
IO_ADDR, 8'hFF, address decoded to the I/O port instead of RAM.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
mem_req  input  1  core request, level, held until mem_ready seen.
mem_addr  input  ADDR_W  request address.
mem_we  input  1  1 = write, 0 = read.
mem_wdata  input  DATA_W  write data (core data_out).
mem_rdata  output  DATA_W  read data to core data_in; registered.
mem_ready  output  1  access complete; registered.
busy  output  1  high when state != IDLE.
io_in  input  DATA_W  value returned on reads of IO_ADDR.
io_out  output  DATA_W  last value written to IO_ADDR.
io_strobe  output  1  one-cycle pulse on each commit of a core write to IO_ADDR.
load_we  input  1  preload write enable.
load_addr  input  ADDR_W  preload address.
load_data  input  DATA_W  preload data.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: mem_rdata = 0, mem_ready = 0, io_out = 0, io_strobe = 0, busy = 0, state = IDLE, wait counter = 0.
- RAM contents are not affected by rst.
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - If mem_req is sampled high, latch addr, we and wdata.
  - Load the counter with WAIT_CYCLES and go to WAIT.
- WAIT:
  - Counter != 0: decrement.
  - Counter == 0: commit the access this edge.
  - Commit with mem_req sampled high: go to RESP and set mem_ready = 1 this edge.
  - Commit with mem_req sampled low (core aborted): go to IDLE and leave mem_ready at 0.
- Commit actions:
  - Write to RAM: writes the RAM.
  - Write to IO_ADDR: sets io_out to the write data and io_strobe = 1 for one cycle; RAM at IO_ADDR is untouched.
  - Read from RAM: mem_rdata <= RAM[addr].
  - Read from IO_ADDR: mem_rdata <= io_in.
  - Write commits: mem_rdata is unchanged.
- Latency: request sampled at edge N gives mem_ready = 1 after edge N+1+WAIT_CYCLES.
- RESP:
  - mem_ready and mem_rdata are held while mem_req stays high.
  - On the first edge mem_req is sampled low: mem_ready <= 0, go to IDLE.
  - A new request can be accepted at the following edge at the earliest.
- Inputs mem_addr, mem_we and mem_wdata are ignored after acceptance, since values were latched in IDLE.
- Aborted reads are discarded. Aborted writes still commit.
- Load port:
  - With load_we = 1, RAM[load_addr] <= load_data on any cycle, in any state.
  - Loads to IO_ADDR are ignored.
  - A load and a core write committing to the same address on the same edge: the core write wins.
  - A load and a read committing to the same address on the same edge: the read returns the pre-load value.
- Reset mid-transaction: return to IDLE with mem_ready = 0. An uncommitted write is dropped and RAM is unchanged.
- Address wrap: addresses are exactly ADDR_W bits; no out-of-range case exists.

Test Plan:
- Preload RAM[0x10] = 0x5A via the load port, WAIT_CYCLES = 2. Read 0x10 with the request at edge N -> mem_ready rises after edge N+3, mem_rdata = 0x5A, and both hold until mem_req drops; mem_ready is low one edge later.
- Write 0x33 to 0x20, then read 0x20 -> 0x33 returned. Write 0x77 to 0xFF -> io_out = 0x77, one io_strobe pulse, and RAM[0xFF] is unchanged when checked by setting io_in = 0x00 and confirming the core read returns io_in, not RAM.
- Core write of 0x11 to 0x40 commits on the same edge as a load of 0x22 to 0x40 -> RAM[0x40] = 0x11. A read commit of 0x41 collides with a load of 0x99 -> old value returned, and a later read gives 0x99.
- Drop mem_req during WAIT on a write of 0xAB to 0x05 -> mem_ready never rises, RAM[0x05] = 0xAB, FSM returns to IDLE.
- Assert rst during WAIT of a write of 0xCD to 0x06 -> RAM[0x06] is unchanged, mem_ready = 0, busy = 0 after that edge.
- WAIT_CYCLES = 0 with back-to-back reads of 0x00..0x03 -> each mem_ready comes one edge after acceptance, with the correct data.
